// File: rtl/dot_table.sv
// Dot-position store with shadow/active tables and a per-scanline hit scanner.
// Shadow takes processor writes; active is refreshed on frame_start so a frame never tears.
module dot_table #(
  parameter int N_DOTS   = 450,
  parameter int ID_W     = 9,
  parameter int COORD_W  = 10,
  parameter int DOT_SIZE = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dotWren,
  input  logic               is_Yloc,
  input  logic [31:0]        dotID,
  input  logic [31:0]        dotLoc,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic [COORD_W-1:0] line_y,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [COORD_W-1:0] hit_x,
  output logic [ID_W-1:0]    hit_id,
  output logic               scan_busy,
  output logic               scan_done,
  output logic               scan_overrun
);
  localparam int               LAST_I  = N_DOTS - 1;
  localparam logic [ID_W-1:0]  LAST    = LAST_I[ID_W-1:0];
  localparam logic [31:0]      NDOTS32 = N_DOTS;
  localparam logic [COORD_W:0] DS      = DOT_SIZE[COORD_W:0];

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t state, state_nxt;
  logic [ID_W-1:0] idx, idx_nxt;
  logic [COORD_W-1:0] lat, lat_nxt;
  logic load, done, overrun;

  logic [N_DOTS-1:0][COORD_W-1:0] sx, sy, ax, ay;
  logic [N_DOTS-1:0] sxs, sys, axs, ays;

  logic wr_ok;
  logic [ID_W-1:0] wid;
  logic unused_loc;
  assign wr_ok = dotWren && (dotID < NDOTS32);
  assign wid = dotID[ID_W-1:0];
  assign unused_loc = ^dotLoc[31:COORD_W];

  // Commit uses nonblocking reads, so active sees shadow as it was before this cycle's write.
  always_ff @(posedge clock) begin
    if (reset) begin
      sx <= '0; sy <= '0; sxs <= '0; sys <= '0;
      ax <= '0; ay <= '0; axs <= '0; ays <= '0;
    end else begin
      if (wr_ok) begin
        if (is_Yloc) begin
          sy[wid]  <= dotLoc[COORD_W-1:0];
          sys[wid] <= 1'b1;
        end else begin
          sx[wid]  <= dotLoc[COORD_W-1:0];
          sxs[wid] <= 1'b1;
        end
      end
      if (frame_start) begin
        ax <= sx; ay <= sy; axs <= sxs; ays <= sys;
      end
    end
  end

  // Compare at COORD_W+1 bits so a dot near the bottom never wraps onto top lines.
  logic [COORD_W:0] lext, yext;
  logic hit;
  assign lext = {1'b0, lat};
  assign yext = {1'b0, ay[idx]};
  assign hit  = axs[idx] && ays[idx] && (yext <= lext) && ((lext - yext) < DS);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    lat_nxt   = lat;
    load      = 1'b0;
    done      = 1'b0;
    overrun   = 1'b0;
    case (state)
      IDLE: if (line_start) begin
        lat_nxt   = line_y;
        idx_nxt   = '0;
        state_nxt = SCAN;
      end
      SCAN: begin
        if (hit) begin
          load      = 1'b1;
          state_nxt = EMIT;
        end else if (idx == LAST) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      EMIT: if (hit_ready) begin
        if (idx == LAST) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = SCAN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new line while busy abandons the current scan, including any unaccepted hit.
    if (line_start && state != IDLE) begin
      overrun   = 1'b1;
      done      = 1'b0;
      load      = 1'b0;
      lat_nxt   = line_y;
      idx_nxt   = '0;
      state_nxt = SCAN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      lat    <= '0;
      hit_x  <= '0;
      hit_id <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      lat   <= lat_nxt;
      if (load) begin
        hit_x  <= ax[idx];
        hit_id <= idx;
      end
    end
  end

  assign hit_valid    = (state == EMIT);
  assign scan_busy    = (state != IDLE);
  assign scan_done    = done && !reset;
  assign scan_overrun = overrun && !reset;
endmodule

// File: tb/tb_dot_table.sv
// Directed bench for dot_table: commit timing, hit windows, stalls, overrun, reset.
module tb_dot_table;
  logic        clock = 1'b0;
  logic        reset, dotWren, is_Yloc, frame_start, line_start, hit_ready;
  logic [31:0] dotID, dotLoc;
  logic [9:0]  line_y;
  logic        hit_valid, scan_busy, scan_done, scan_overrun;
  logic [9:0]  hit_x;
  logic [8:0]  hit_id;

  int errors = 0;
  int checks = 0;
  int hq_id[$];
  int hq_x[$];
  int hq_c[$];

  always #5 clock = ~clock;

  dot_table dut (
    .clock(clock), .reset(reset), .dotWren(dotWren), .is_Yloc(is_Yloc),
    .dotID(dotID), .dotLoc(dotLoc), .frame_start(frame_start),
    .line_start(line_start), .line_y(line_y), .hit_valid(hit_valid),
    .hit_ready(hit_ready), .hit_x(hit_x), .hit_id(hit_id),
    .scan_busy(scan_busy), .scan_done(scan_done), .scan_overrun(scan_overrun)
  );

  // Cycle start: inputs are set here, outputs sampled 4ns later (mid-cycle).
  task automatic nxt();
    @(posedge clock); #1;
  endtask

  task automatic write_dot(input int id, input logic y, input int loc);
    dotWren = 1'b1; is_Yloc = y; dotID = id; dotLoc = loc;
    nxt();
    dotWren = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    nxt();
    frame_start = 1'b0;
  endtask

  // Starts from the cycle after line_start; c counts cycles since line_start.
  task automatic collect(output int done_c);
    bit fin = 0;
    hq_id.delete(); hq_x.delete(); hq_c.delete();
    done_c = -1;
    for (int c = 1; c <= 2000 && !fin; c++) begin
      #4;
      if (hit_valid && hit_ready) begin
        hq_id.push_back(int'(hit_id)); hq_x.push_back(int'(hit_x)); hq_c.push_back(c);
      end
      if (scan_done) begin
        done_c = c;
        fin = 1;
      end
      nxt();
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL scan_timeout: no scan_done within 2000 cycles");
    end
    #4;
    checks++;
    if (scan_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: scan_busy=%b want 0", scan_busy);
    end
    nxt();
  endtask

  task automatic run_scan(input int y, output int done_c);
    line_start = 1'b1; line_y = y[9:0];
    #4;
    checks++;
    if (scan_overrun !== 1'b0 || scan_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_start: overrun=%b busy=%b want 0 0", scan_overrun, scan_busy);
    end
    nxt();
    line_start = 1'b0;
    collect(done_c);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    nxt(); nxt();
    reset = 1'b0;
    #4;
    checks++;
    if ({hit_valid, scan_busy, scan_done, scan_overrun, hit_x, hit_id} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b ovr=%b x=%0d id=%0d want all 0",
               hit_valid, scan_busy, scan_done, scan_overrun, hit_x, hit_id);
    end
    nxt();
  endtask

  task automatic test_empty_scan();
    int d;
    run_scan(0, d);
    checks++;
    if (hq_id.size() != 0 || d != 450) begin
      errors++;
      $display("FAIL empty_scan: hits=%0d done_at=%0d want 0 450", hq_id.size(), d);
    end
  endtask

  task automatic test_single_dot();
    int d;
    write_dot(5, 0, 100);
    write_dot(5, 1, 200);
    frame();
    run_scan(203, d);
    checks++;
    if (hq_id.size() != 1 || d != 451) begin
      errors++;
      $display("FAIL single_count: hits=%0d done_at=%0d want 1 451", hq_id.size(), d);
    end else begin
      checks++;
      if (hq_id[0] != 5 || hq_x[0] != 100 || hq_c[0] != 7) begin
        errors++;
        $display("FAIL single_hit: id=%0d x=%0d cyc=%0d want 5 100 7", hq_id[0], hq_x[0], hq_c[0]);
      end
    end
    run_scan(200, d);
    checks++;
    if (hq_id.size() != 1) begin
      errors++;
      $display("FAIL top_edge: hits=%0d want 1", hq_id.size());
    end
    run_scan(204, d);
    checks++;
    if (hq_id.size() != 0 || d != 450) begin
      errors++;
      $display("FAIL below_dot: hits=%0d done_at=%0d want 0 450", hq_id.size(), d);
    end
    run_scan(199, d);
    checks++;
    if (hq_id.size() != 0) begin
      errors++;
      $display("FAIL above_dot: hits=%0d want 0", hq_id.size());
    end
  endtask

  task automatic test_commit_same_cycle();
    int d;
    write_dot(7, 0, 300);
    dotWren = 1'b1; is_Yloc = 1'b1; dotID = 7; dotLoc = 400; frame_start = 1'b1;
    nxt();
    dotWren = 1'b0; frame_start = 1'b0;
    run_scan(400, d);
    checks++;
    if (hq_id.size() != 0) begin
      errors++;
      $display("FAIL same_cycle_commit: hits=%0d want 0", hq_id.size());
    end
    frame();
    run_scan(400, d);
    checks++;
    if (hq_id.size() != 1 || hq_id[0] != 7 || hq_x[0] != 300) begin
      errors++;
      $display("FAIL second_commit: hits=%0d first_id=%0d want 1 hit id 7 x 300",
               hq_id.size(), hq_id.size() > 0 ? hq_id[0] : -1);
    end
  endtask

  task automatic test_stall();
    int stall = 0, unstable = 0, first_c = -1, d = -1;
    bit fin = 0;
    write_dot(3, 0, 11); write_dot(3, 1, 50);
    write_dot(9, 0, 22); write_dot(9, 1, 50);
    frame();
    hit_ready = 1'b0;
    hq_id.delete(); hq_x.delete();
    line_start = 1'b1; line_y = 52;
    nxt();
    line_start = 1'b0;
    for (int c = 1; c <= 2000 && !fin; c++) begin
      #4;
      if (hit_valid && !hit_ready) begin
        if (first_c < 0) first_c = c;
        stall++;
        if (hit_id !== 9'd3 || hit_x !== 10'd11) unstable++;
      end
      if (hit_valid && hit_ready) begin
        hq_id.push_back(int'(hit_id)); hq_x.push_back(int'(hit_x));
      end
      if (scan_done) begin d = c; fin = 1; end
      nxt();
      hit_ready = (stall >= 10);
    end
    hit_ready = 1'b1;
    checks++;
    if (first_c != 5 || stall != 10 || unstable != 0) begin
      errors++;
      $display("FAIL stall_hold: first=%0d stalled=%0d unstable=%0d want 5 10 0", first_c, stall, unstable);
    end
    checks++;
    if (hq_id.size() != 2 || d != 462) begin
      errors++;
      $display("FAIL stall_scan: hits=%0d done_at=%0d want 2 462", hq_id.size(), d);
    end else begin
      checks++;
      if (hq_id[0] != 3 || hq_x[0] != 11 || hq_id[1] != 9 || hq_x[1] != 22) begin
        errors++;
        $display("FAIL stall_order: %0d/%0d then %0d/%0d want 3/11 then 9/22",
                 hq_id[0], hq_x[0], hq_id[1], hq_x[1]);
      end
    end
    nxt();
  endtask

  task automatic test_overrun();
    int d;
    bit seen = 0;
    hit_ready = 1'b0;
    line_start = 1'b1; line_y = 50;
    nxt();
    line_start = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      #4;
      if (hit_valid) seen = 1;
      nxt();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL overrun_setup: no pending hit within 20 cycles");
    end
    line_start = 1'b1; line_y = 400;
    #4;
    checks++;
    if (scan_overrun !== 1'b1 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pulse: ovr=%b done=%b want 1 0", scan_overrun, scan_done);
    end
    nxt();
    line_start = 1'b0; hit_ready = 1'b1;
    collect(d);
    checks++;
    if (hq_id.size() != 1 || d != 451) begin
      errors++;
      $display("FAIL overrun_restart: hits=%0d done_at=%0d want 1 451", hq_id.size(), d);
    end else begin
      checks++;
      if (hq_id[0] != 7 || hq_x[0] != 300 || hq_c[0] != 9) begin
        errors++;
        $display("FAIL overrun_hit: id=%0d x=%0d cyc=%0d want 7 300 9", hq_id[0], hq_x[0], hq_c[0]);
      end
    end
  endtask

  task automatic test_bad_ids();
    int d;
    write_dot(450, 1, 600);
    write_dot(1000, 1, 600);
    write_dot(515, 1, 600);
    write_dot(515, 0, 77);
    frame();
    run_scan(52, d);
    checks++;
    if (hq_id.size() != 2 || d != 452) begin
      errors++;
      $display("FAIL bad_id_ignored: hits=%0d done_at=%0d want 2 452", hq_id.size(), d);
    end
    run_scan(600, d);
    checks++;
    if (hq_id.size() != 0) begin
      errors++;
      $display("FAIL bad_id_y600: hits=%0d want 0", hq_id.size());
    end
  endtask

  task automatic test_nowrap_and_reset();
    int d;
    bit seen = 0;
    write_dot(0, 0, 1);
    write_dot(0, 1, 1022);
    frame();
    run_scan(1, d);
    checks++;
    if (hq_id.size() != 0) begin
      errors++;
      $display("FAIL no_wrap: hits=%0d want 0", hq_id.size());
    end
    run_scan(1023, d);
    checks++;
    if (hq_id.size() != 1 || hq_id[0] != 0 || hq_x[0] != 1 || hq_c[0] != 2) begin
      errors++;
      $display("FAIL entry0_hit: hits=%0d want 1 (id 0 x 1 at cycle 2)", hq_id.size());
    end
    hit_ready = 1'b0;
    line_start = 1'b1; line_y = 1023;
    nxt();
    line_start = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      #4;
      if (hit_valid) seen = 1;
      nxt();
    end
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    #4;
    checks++;
    if (!seen || {hit_valid, scan_busy, scan_done, scan_overrun, hit_x, hit_id} !== '0) begin
      errors++;
      $display("FAIL reset_mid_emit: seen=%b valid=%b busy=%b x=%0d id=%0d want 1 0 0 0 0",
               seen, hit_valid, scan_busy, hit_x, hit_id);
    end
    nxt();
    hit_ready = 1'b1;
    run_scan(1023, d);
    checks++;
    if (hq_id.size() != 0) begin
      errors++;
      $display("FAIL reset_clears_table: hits=%0d want 0", hq_id.size());
    end
  endtask

  initial begin
    reset = 1'b1; dotWren = 1'b0; is_Yloc = 1'b0; dotID = '0; dotLoc = '0;
    frame_start = 1'b0; line_start = 1'b0; line_y = '0; hit_ready = 1'b1;
    test_reset();
    test_empty_scan();
    test_single_dot();
    test_commit_same_cycle();
    test_stall();
    test_overrun();
    test_bad_ids();
    test_nowrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dot_table.md
# dot_table

Dot-position store and scanline hit generator that terminates the processor's memory-mapped dot-write interface (`dotWren`, `is_Yloc`, `dotID`, `dotLoc`) on the VGA side. Processor writes land in a shadow table. The shadow table is copied to an active table at each frame start, so dots never tear mid-frame. On each scanline start, an FSM walks the active table and streams the IDs and X positions of dots that cover that line, for the pixel renderer to consume.

## Interface
Parameters:
- `N_DOTS`, 450: table entries; valid `dotID` range is 0..N_DOTS-1.
- `ID_W`, 9: width of dot index outputs.
- `COORD_W`, 10: stored coordinate width.
- `DOT_SIZE`, 4: dot height in lines.

Ports:
- `clock`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high.
- `dotWren`, in, 1: write strobe, one cycle per write.
- `is_Yloc`, in, 1: 1 writes the Y coordinate, 0 writes the X coordinate.
- `dotID`, in, 32: target entry.
- `dotLoc`, in, 32: coordinate; low `COORD_W` bits are used.
- `frame_start`, in, 1: one-cycle pulse that commits shadow to active.
- `line_start`, in, 1: one-cycle pulse that starts a scan of `line_y`.
- `line_y`, in, COORD_W: scanline index, sampled when `line_start` is high.
- `hit_valid`, out, 1: hit available.
- `hit_ready`, in, 1: consumer accepts the hit.
- `hit_x`, out, COORD_W: X coordinate of the hit dot.
- `hit_id`, out, ID_W: index of the hit dot.
- `scan_busy`, out, 1: FSM is not IDLE.
- `scan_done`, out, 1: one-cycle pulse when a scan completes normally.
- `scan_overrun`, out, 1: one-cycle pulse when `line_start` arrives while busy.

## Operation
- Per entry, shadow and active tables each hold `x[COORD_W]`, `y[COORD_W]`, `xs` (X seen) and `ys` (Y seen).
- Write, when `dotWren` is high and `dotID < N_DOTS`:
  - `is_Yloc=0`: shadow `x <= dotLoc[COORD_W-1:0]`, `xs <= 1`.
  - `is_Yloc=1`: shadow `y <= dotLoc[COORD_W-1:0]`, `ys <= 1`.
  - Writes with `dotID >= N_DOTS` are ignored silently.
- Commit: when `frame_start` is high, every active entry takes its shadow entry's value as it was before this cycle's write. A write in the same cycle lands in shadow and becomes visible at the next `frame_start`.
- An entry is live when active `xs & ys` is 1.
- Hit test, done at COORD_W+1 bits with no wrap: entry is live and `y <= L` and `L - y < DOT_SIZE`, where `L` is the latched line.
- FSM states: IDLE, SCAN, EMIT.
  - IDLE: on `line_start`, latch `L <= line_y`, set `idx <= 0`, go to SCAN.
  - SCAN: test entry `idx` each cycle.
    - Hit: load `hit_x`/`hit_id`, go to EMIT.
    - Miss with `idx == N_DOTS-1`: pulse `scan_done`, go to IDLE.
    - Otherwise: `idx <= idx + 1`.
  - EMIT: hold `hit_valid=1` with stable `hit_x`/`hit_id` until `hit_ready`. On the accepting cycle:
    - If `idx == N_DOTS-1`: pulse `scan_done` and go to IDLE.
    - Else: `idx <= idx + 1`, go to SCAN.
- `line_start` in SCAN or EMIT:
  - pulse `scan_overrun`;
  - drop any pending hit (`hit_valid` low next cycle, with no handshake);
  - relatch `L`, restart at `idx=0` in SCAN.
- `frame_start` during a scan commits immediately. The remaining entries are tested against the new active values.

## Timing
- Reset values:
  - all table fields 0 (no live dots);
  - FSM in IDLE, `idx=0`;
  - `hit_valid=0`, `hit_x=0`, `hit_id=0`;
  - `scan_busy=0`, `scan_done=0`, `scan_overrun=0`.
- Reset has priority over writes, commits and scans. Reset mid-scan returns to IDLE the next cycle.
- Write to shadow: visible in shadow on the next edge. Visible to the scanner one cycle after the following `frame_start`.
- `line_start` at cycle T: `scan_busy=1` from T+1. Entry 0 is tested in cycle T+1.
- A hit on entry k with `hit_ready` tied high:
  - `hit_valid` rises at T+2+k;
  - each accepted hit adds exactly one cycle to the scan.
- Scan length with `hit_ready=1` and h hits: `N_DOTS + h` cycles. `scan_done` pulses in the last cycle. The FSM is in IDLE the next cycle.
- Hits are emitted in ascending `idx` order. `hit_x`/`hit_id` must not change while `hit_valid & !hit_ready`.

## Test plan
- Reset, then `line_start` with `line_y=0` and `frame_start` never pulsed:
  - no `hit_valid` for the whole scan;
  - `scan_done` exactly N_DOTS cycles after `line_start`.
- Write dot 5 with X=100, Y=200, then `frame_start`, then `line_start` with `line_y=203`:
  - one hit, `hit_id=5`, `hit_x=100`.
  - Repeat with `line_y=204` and with `line_y=199`: no hit.
- Write X then Y for dot 7 in the same cycle as `frame_start`, then scan `line_y=Y`: no hit. After a second `frame_start`, the same scan hits.
- Dots 3 and 9 both at Y=50, `hit_ready` held low for 10 cycles:
  - `hit_id=3` held stable with `hit_x` unchanged until ready;
  - then `hit_id=9`;
  - `scan_done` follows.
- `line_start` mid-scan: `scan_overrun` pulses, the pending hit is dropped, and the scan restarts with the new `line_y`. Write with `dotID=450` or `dotID=1000`: no table change.
- Dot 0 at Y=1022, `line_y=1`: no hit (no wrap). Assert reset mid-EMIT: every output returns to 0 the next cycle.
